// File: rtl/io_ctrl.sv
// io_ctrl: UART-side I/O glue. Received bytes are buffered and packed into
// 32-bit words for the CPU; outgoing bytes are queued and handed to the
// transmitter one at a time by a small handshake FSM.
module io_ctrl #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        recv_valid,
  output logic [31:0] recv_word,
  input  logic        read_ack,
  input  logic        tx_req,
  input  logic [7:0]  tx_byte,
  output logic        tx_stall,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        rx_overrun
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [2:0]     WORD_BYTES = 3'd4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT,
    TX_BUSY
  } tx_state_e;

  // ---------------------------------------------------------------------
  // Receive side
  // ---------------------------------------------------------------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d;
  logic [RX_AW-1:0] rx_rd_q, rx_rd_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic             recv_valid_q;
  logic             overrun_q, overrun_d;

  assign rx_full  = (rx_cnt_q == RX_FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = (byte_cnt_q < WORD_BYTES) && !rx_empty;
  // A full FIFO still takes a byte when the word assembler frees a slot.
  assign rx_push  = rx_valid && (!rx_full || rx_pop);

  // NOTE: every signal driven here is given a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    rx_cnt_d   = rx_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    overrun_d  = overrun_q | (rx_valid & rx_full & ~rx_pop);

    if (rx_push) rx_wr_d = rx_wr_q + RX_AW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + RX_AW'(1);

    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + (RX_AW + 1)'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - (RX_AW + 1)'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase

    if (rx_pop) begin
      word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = rx_mem[rx_rd_q];
      byte_cnt_d = byte_cnt_q + 3'd1;
    end else if (read_ack && recv_valid_q) begin
      byte_cnt_d = '0;
    end
  end

  // NOTE: FIFO storage carries no reset; the pointers and counts alone
  // decide what is valid, so clearing the array would only cost area.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_data;
  end

  // ---------------------------------------------------------------------
  // Transmit side
  // ---------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d;
  logic [TX_AW-1:0] tx_rd_q, tx_rd_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  tx_state_e        tx_state_q, tx_state_d;
  logic             wait_q, wait_d;
  logic [7:0]       tx_data_q, tx_data_d;

  assign tx_full  = (tx_cnt_q == TX_FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = tx_req && !tx_full;

  always_comb begin
    tx_state_d = tx_state_q;
    wait_d     = wait_q;
    tx_pop     = 1'b0;
    tx_start   = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_start   = 1'b1;
        wait_d     = 1'b0;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: begin
        // Give the transmitter two cycles to raise busy; a short frame may
        // already be over, so a silent transmitter sends us back to idle.
        if (tx_busy)      tx_state_d = TX_BUSY;
        else if (wait_q)  tx_state_d = TX_IDLE;
        else              wait_d     = 1'b1;
      end
      TX_BUSY: begin
        if (!tx_busy) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_wr_d   = tx_wr_q;
    tx_rd_d   = tx_rd_q;
    tx_cnt_d  = tx_cnt_q;
    tx_data_d = tx_data_q;

    if (tx_push) tx_wr_d = tx_wr_q + TX_AW'(1);
    if (tx_pop) begin
      tx_rd_d   = tx_rd_q + TX_AW'(1);
      tx_data_d = tx_mem[tx_rd_q];
    end

    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + (TX_AW + 1)'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - (TX_AW + 1)'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= tx_byte;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: non-blocking assignments make every flop sample the pre-edge value
  // of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      recv_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_cnt_q     <= '0;
      tx_state_q   <= TX_IDLE;
      wait_q       <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      rx_cnt_q     <= rx_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      recv_valid_q <= (byte_cnt_d == WORD_BYTES);
      overrun_q    <= overrun_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_state_q   <= tx_state_d;
      wait_q       <= wait_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign recv_valid = recv_valid_q;
  assign recv_word  = word_q;
  assign rx_overrun = overrun_q;
  assign tx_stall   = tx_full;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: word-assembly vector table, directed
// corner sequences, and randomized RX/TX traffic against a queue model.
module tb_io_ctrl;

  localparam int RX_DEPTH    = 16;
  localparam int TX_DEPTH    = 8;
  localparam int XMIT_CYCLES = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        recv_valid;
  logic [31:0] recv_word;
  logic        read_ack = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_byte = '0;
  logic        tx_stall;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        rx_overrun;

  io_ctrl #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .recv_valid (recv_valid),
    .recv_word  (recv_word),
    .read_ack   (read_ack),
    .tx_req     (tx_req),
    .tx_byte    (tx_byte),
    .tx_stall   (tx_stall),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for XMIT_CYCLES after each start (unless
  // skip_busy models a transmitter that never reports busy).
  int         busy_cnt = 0;
  logic       force_busy = 1'b0;
  logic       skip_busy = 1'b0;
  logic       mon_busy;
  logic [7:0] tx_cur = '0;
  logic [7:0] tx_exp [$];
  int         n_starts = 0;
  int         cyc = 0;
  int         start_cyc [$];

  assign tx_busy = force_busy || (busy_cnt > 0);

  always @(negedge clk) begin
    cyc++;
    mon_busy = tx_busy;
    if (busy_cnt > 0) begin
      check("tx_data_hold", 32'(tx_data), 32'(tx_cur));
      busy_cnt--;
    end
    if (tx_start) begin
      n_starts++;
      start_cyc.push_back(cyc);
      check("tx_start_while_busy", 32'(mon_busy), 32'd0);
      if (tx_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_unexpected: byte %h started with nothing queued (t=%0t)", tx_data, $time);
      end else begin
        tx_cur = tx_exp.pop_front();
        check("tx_order", 32'(tx_data), 32'(tx_cur));
      end
      if (!skip_busy) busy_cnt = XMIT_CYCLES;
    end
  end

  // ---------------- helper tasks (all start and end on a negedge) ---------
  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_rv(input string name);
    int g = 0;
    while (!recv_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check(name, 32'(recv_valid), 32'd1);
  endtask

  task automatic ack_word(input string name, input logic [31:0] exp);
    wait_rv({name, "_valid"});
    check(name, recv_word, exp);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    check({name, "_ack"}, 32'(recv_valid), 32'd0);
  endtask

  task automatic tx_send(input logic [7:0] b);
    int waited = 0;
    tx_req  = 1'b1;
    tx_byte = b;
    while (tx_stall && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("tx_send_accept", 32'(tx_stall), 32'd0);
    if (!tx_stall) tx_exp.push_back(b);
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic tx_drain(input string name);
    int g = 0;
    while ((tx_exp.size() != 0 || tx_busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check(name, 32'(tx_exp.size()), 32'd0);
  endtask

  // ---------------- word-assembly vector table ---------------------------
  // seq lists the four bytes in arrival order, first byte in the MSBs.
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] word;
  } rx_vec_t;

  task automatic apply_vec(input rx_vec_t v);
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1'b1;
      rx_data  = v.seq[31 - 8 * k -: 8];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("vec_not_yet_valid", 32'(recv_valid), 32'd0);
    @(negedge clk);
    check("vec_valid_at_5", 32'(recv_valid), 32'd1);
    check("vec_word", recv_word, v.word);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    check("vec_ack_clear", 32'(recv_valid), 32'd0);
  endtask

  // ---------------- randomized traffic with queue model ------------------
  int         rx_out = 0;
  logic [7:0] rx_exp [$];

  task automatic rx_producer(input int n);
    int sent = 0;
    int guard = 0;
    logic [7:0] b;
    while (sent < n && guard < 4000) begin
      if (rx_out < RX_DEPTH && $urandom_range(0, 2) != 0) begin
        b = 8'($urandom);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_exp.push_back(b);
        rx_out++;
        sent++;
      end else begin
        rx_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    rx_valid = 1'b0;
  endtask

  task automatic rx_consumer(input int n_words);
    int words = 0;
    int guard = 0;
    logic [31:0] w;
    while (words < n_words && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (recv_valid && rx_exp.size() >= 4 && $urandom_range(0, 3) == 0) begin
        w = '0;
        for (int k = 0; k < 4; k++) w = w | (32'(rx_exp.pop_front()) << (8 * k));
        check("rand_word", recv_word, w);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
        check("rand_ack_clear", 32'(recv_valid), 32'd0);
        rx_out -= 4;
        words++;
      end
    end
    check("rand_word_count", 32'(words), 32'(n_words));
  endtask

  task automatic tx_producer(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      tx_send(8'($urandom));
    end
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    rx_vec_t vecs [5];
    int      s0;
    int      g;

    vecs[0] = '{seq: 32'h78563412, word: 32'h12345678};
    vecs[1] = '{seq: 32'hA55AC33C, word: 32'h3CC35AA5};
    vecs[2] = '{seq: 32'hFFFFFFFF, word: 32'hFFFFFFFF};
    vecs[3] = '{seq: 32'h00000080, word: 32'h80000000};
    vecs[4] = '{seq: 32'h01020304, word: 32'h04030201};

    repeat (2) @(negedge clk);
    check("rst_recv_valid", 32'(recv_valid), 32'd0);
    check("rst_recv_word", recv_word, 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_stall", 32'(tx_stall), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_no_start", 32'(n_starts), 32'd0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // read_ack on a partial word must be ignored
    rx_byte(8'h10);
    rx_byte(8'h20);
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    check("ack_ignored_valid", 32'(recv_valid), 32'd0);
    rx_byte(8'h30);
    rx_byte(8'h40);
    ack_word("ack_ignored_word", 32'h40302010);

    // eight bytes with no ack: first word held, rest waits in the FIFO
    for (int i = 1; i <= 8; i++) rx_byte(8'(i));
    wait_rv("hold_valid");
    check("hold_word", recv_word, 32'h04030201);
    repeat (6) @(negedge clk);
    check("hold_word_stable", recv_word, 32'h04030201);
    ack_word("hold_first", 32'h04030201);
    ack_word("hold_second", 32'h08070605);

    // randomized concurrent RX/TX traffic
    fork
      rx_producer(64);
      rx_consumer(16);
      tx_producer(20);
    join
    tx_drain("rand_tx_drain");
    check("rand_no_overrun", 32'(rx_overrun), 32'd0);

    // two bytes through a 10-cycle-busy transmitter
    s0 = n_starts;
    tx_send(8'h41);
    tx_send(8'h42);
    tx_drain("two_bytes_drain");
    check("two_bytes_starts", 32'(n_starts - s0), 32'd2);

    // transmitter that never raises busy: WAIT times out after two cycles
    skip_busy = 1'b1;
    s0 = start_cyc.size();
    tx_send(8'hC1);
    tx_send(8'hC2);
    tx_send(8'hC3);
    tx_drain("nobusy_drain");
    check("nobusy_starts", 32'(start_cyc.size() - s0), 32'd3);
    if (start_cyc.size() >= s0 + 3) begin
      check("nobusy_gap1", 32'(start_cyc[s0 + 1] - start_cyc[s0]), 32'd4);
      check("nobusy_gap2", 32'(start_cyc[s0 + 2] - start_cyc[s0 + 1]), 32'd4);
    end
    skip_busy = 1'b0;

    // fill TX FIFO while transmitter is held busy, then hold one extra request
    force_busy = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < TX_DEPTH; i++) tx_send(8'(8'h60 + i));
    check("tx_full_stall", 32'(tx_stall), 32'd1);
    tx_req  = 1'b1;
    tx_byte = 8'h99;
    repeat (5) @(negedge clk);
    check("tx_stall_held", 32'(tx_stall), 32'd1);
    check("tx_no_start_busy", 32'(n_starts - s0), 32'd0);
    force_busy = 1'b0;
    tx_send(8'h99);
    tx_drain("tx_full_drain");
    check("tx_full_starts", 32'(n_starts - s0), 32'(TX_DEPTH + 1));
    check("tx_stall_cleared", 32'(tx_stall), 32'd0);

    // RX overrun: RX_DEPTH+5 bytes with no ack drops exactly the last one
    for (int i = 0; i < RX_DEPTH + 5; i++) rx_byte(8'(8'h80 + i));
    check("ovr_set", 32'(rx_overrun), 32'd1);
    for (int w = 0; w < (RX_DEPTH + 4) / 4; w++)
      ack_word("ovr_word", {8'(8'h83 + 4 * w), 8'(8'h82 + 4 * w),
                            8'(8'h81 + 4 * w), 8'(8'h80 + 4 * w)});
    rx_byte(8'hA0);
    rx_byte(8'hA1);
    rx_byte(8'hA2);
    rx_byte(8'hA3);
    ack_word("ovr_after_word", 32'hA3A2A1A0);
    check("ovr_sticky", 32'(rx_overrun), 32'd1);

    // reset in the middle of a transmission with a partial word
    rx_byte(8'h11);
    rx_byte(8'h22);
    s0 = n_starts;
    tx_send(8'h55);
    g = 0;
    while (n_starts == s0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("mid_setup_start", 32'(n_starts - s0), 32'd1);
    repeat (4) @(negedge clk);
    #2;
    rstn     = 1'b0;
    busy_cnt = 0;
    tx_exp.delete();
    #1;
    check("mid_rst_recv_valid", 32'(recv_valid), 32'd0);
    check("mid_rst_recv_word", recv_word, 32'd0);
    check("mid_rst_overrun", 32'(rx_overrun), 32'd0);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_tx_stall", 32'(tx_stall), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    s0 = n_starts;
    repeat (6) @(negedge clk);
    check("mid_rst_no_start", 32'(n_starts - s0), 32'd0);
    check("mid_rst_tx_idle", 32'(tx_data), 32'd0);
    rx_byte(8'hDE);
    rx_byte(8'hAD);
    rx_byte(8'hBE);
    rx_byte(8'hEF);
    ack_word("mid_rst_fresh_word", 32'hEFBEADDE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
